// File: rtl/ifetch_queue.sv
// ifetch_queue: sequential PC generator with one outstanding fetch and a
// circular instruction queue presented to decode via valid/ready.
// Optional JAL target prediction is enabled by defining IFETCH_JAL_PREDICT_EN.
module ifetch_queue #(
  parameter int unsigned QUEUE_DEPTH_LOG = 3,
  parameter logic [31:0] RESET_PC        = 32'h0
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  output logic        mem_req_valid,
  output logic [31:0] mem_req_addr,
  input  logic        mem_resp_valid,
  input  logic [31:0] mem_resp_data,
  output logic        instr_valid,
  output logic [31:0] instr_out,
  output logic [31:0] instr_pc,
  output logic        instr_pred_taken,
  input  logic        issue_ready,
  input  logic        flush_in,
  input  logic [31:0] flush_pc
);

  localparam int unsigned DEPTH = 1 << QUEUE_DEPTH_LOG;
  localparam int unsigned CW    = QUEUE_DEPTH_LOG + 1;
  localparam int unsigned PW    = QUEUE_DEPTH_LOG;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_WAIT  = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

  logic [1:0]    state_q, state_d;
  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic          req_valid_q, req_valid_d;
  logic [31:0]   req_addr_q, req_addr_d;
  logic          push;
  logic          pop;
  logic [31:0]   seq_next_pc;

  logic [PW-1:0] head_q, tail_q;
  logic [CW-1:0] count_q;
  logic [31:0]   instr_mem [DEPTH];
  logic [31:0]   pc_mem    [DEPTH];

`ifdef IFETCH_JAL_PREDICT_EN
  logic          pred_mem  [DEPTH];
  logic          is_jal;
  logic [31:0]   jal_imm;

  // JAL decode of the returning word; target is relative to its own PC
  always_comb begin
    is_jal      = (mem_resp_data[6:0] == 7'b1101111);
    jal_imm     = {{11{mem_resp_data[31]}}, mem_resp_data[31], mem_resp_data[19:12],
                   mem_resp_data[20], mem_resp_data[30:21], 1'b0};
    seq_next_pc = is_jal ? (req_addr_q + jal_imm) : (fetch_pc_q + 32'd4);
  end
`else
  // Next sequential fetch address
  always_comb begin
    seq_next_pc = fetch_pc_q + 32'd4;
  end
`endif

  // Fetch FSM next-state and request control
  always_comb begin
    state_d     = state_q;
    fetch_pc_d  = fetch_pc_q;
    req_valid_d = req_valid_q;
    req_addr_d  = req_addr_q;
    push        = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (flush_in) begin
          fetch_pc_d = flush_pc;
        end else if (count_q < CW'(DEPTH)) begin
          req_valid_d = 1'b1;
          req_addr_d  = fetch_pc_q;
          state_d     = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (flush_in) begin
          fetch_pc_d = flush_pc;
          if (mem_resp_valid) begin
            req_valid_d = 1'b0;
            state_d     = ST_IDLE;
          end else begin
            // Controller cannot abort: keep the request up until it answers
            state_d = ST_DRAIN;
          end
        end else if (mem_resp_valid) begin
          push        = 1'b1;
          fetch_pc_d  = seq_next_pc;
          req_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      ST_DRAIN: begin
        if (flush_in) begin
          fetch_pc_d = flush_pc;
        end
        if (mem_resp_valid) begin
          req_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      default: begin
        req_valid_d = 1'b0;
        state_d     = ST_IDLE;
      end
    endcase
  end

  // Fetch FSM state and request registers
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q     <= ST_IDLE;
      fetch_pc_q  <= RESET_PC;
      req_valid_q <= 1'b0;
      req_addr_q  <= 32'h0;
    end else if (rdy_in) begin
      state_q     <= state_d;
      fetch_pc_q  <= fetch_pc_d;
      req_valid_q <= req_valid_d;
      req_addr_q  <= req_addr_d;
    end
  end

  assign pop = (count_q != '0) && issue_ready && !flush_in;

  // Queue pointers and occupancy
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else if (rdy_in) begin
      if (flush_in) begin
        head_q  <= '0;
        tail_q  <= '0;
        count_q <= '0;
      end else begin
        if (push) begin
          tail_q <= tail_q + PW'(1);
        end
        if (pop) begin
          head_q <= head_q + PW'(1);
        end
        case ({push, pop})
          2'b10:   count_q <= count_q + CW'(1);
          2'b01:   count_q <= count_q - CW'(1);
          default: count_q <= count_q;
        endcase
      end
    end
  end

  // Queue storage; entries are only visible while counted, so no reset
  always_ff @(posedge clk_in) begin
    if (!rst_in && rdy_in && push) begin
      instr_mem[tail_q] <= mem_resp_data;
      pc_mem[tail_q]    <= req_addr_q;
`ifdef IFETCH_JAL_PREDICT_EN
      pred_mem[tail_q]  <= is_jal;
`endif
    end
  end

  assign mem_req_valid = req_valid_q;
  assign mem_req_addr  = req_addr_q;
  assign instr_valid   = (count_q != '0);
  assign instr_out     = instr_valid ? instr_mem[head_q] : 32'h0;
  assign instr_pc      = instr_valid ? pc_mem[head_q]    : 32'h0;
`ifdef IFETCH_JAL_PREDICT_EN
  assign instr_pred_taken = instr_valid & pred_mem[head_q];
`else
  assign instr_pred_taken = 1'b0;
`endif

endmodule
